// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store sequencer between execute and data memory.
// Latches an operation on the execute handshake, checks funct3 legality and alignment,
// drives a word-aligned memory request with byte enables and lane-replicated store data,
// and returns right-aligned load data plus the extension select code.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    // execute side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    // memory request port
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    // memory response port
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    // completion
    output logic        resp_valid,
    output logic        resp_rf_we,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic [2:0]  resp_ldx_sel,
    // exception
    output logic        exc_valid,
    output logic [31:0] exc_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // extension select codes for the downstream load-extension unit
    localparam logic [2:0] LDX_LW  = 3'b000;
    localparam logic [2:0] LDX_LHU = 3'b001;
    localparam logic [2:0] LDX_LH  = 3'b010;
    localparam logic [2:0] LDX_LBU = 3'b011;
    localparam logic [2:0] LDX_LB  = 3'b100;

    state_t      r_state;

    // latched operation context
    logic        r_is_store;
    logic [4:0]  r_rd;
    logic [1:0]  r_offset;
    logic [2:0]  r_ldx_sel;

    // registered outputs
    logic        r_mem_req_valid;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_we;
    logic [31:0] r_mem_wdata;
    logic        r_resp_valid;
    logic        r_resp_rf_we;
    logic [4:0]  r_resp_rd;
    logic [31:0] r_resp_data;
    logic [2:0]  r_resp_ldx_sel;
    logic        r_exc_valid;
    logic [31:0] r_exc_addr;

    // decode results for the operation currently presented by execute
    logic        w_accept;
    logic        w_legal;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_misaligned;
    logic        w_fault;
    logic [2:0]  w_ldx_sel;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_load_aligned;

    assign req_ready = (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;

    // funct3 decode: legality, access size and load extension code
    always_comb begin
        w_legal   = 1'b0;
        w_is_word = 1'b0;
        w_is_half = 1'b0;
        w_ldx_sel = LDX_LW;
        if (req_is_store) begin
            case (req_funct3)
                3'b000: w_legal = 1'b1;
                3'b001: begin
                    w_legal   = 1'b1;
                    w_is_half = 1'b1;
                end
                3'b010: begin
                    w_legal   = 1'b1;
                    w_is_word = 1'b1;
                end
                default: w_legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000: begin
                    w_legal   = 1'b1;
                    w_ldx_sel = LDX_LB;
                end
                3'b001: begin
                    w_legal   = 1'b1;
                    w_is_half = 1'b1;
                    w_ldx_sel = LDX_LH;
                end
                3'b010: begin
                    w_legal   = 1'b1;
                    w_is_word = 1'b1;
                    w_ldx_sel = LDX_LW;
                end
                3'b100: begin
                    w_legal   = 1'b1;
                    w_ldx_sel = LDX_LBU;
                end
                3'b101: begin
                    w_legal   = 1'b1;
                    w_is_half = 1'b1;
                    w_ldx_sel = LDX_LHU;
                end
                default: w_legal = 1'b0;
            endcase
        end
    end

    assign w_misaligned = (w_is_word && (req_addr[1:0] != 2'b00)) ||
                          (w_is_half && req_addr[0]);
    assign w_fault      = !w_legal || w_misaligned;

    // per-lane byte enable and store data; a half store only reaches here with addr[0] = 0,
    // so addr[1] alone selects its lane pair
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            assign w_be[gi] = req_is_store &&
                              (w_is_word ||
                               (w_is_half ? (req_addr[1] == LANE[1])
                                          : (req_addr[1:0] == LANE)));

            assign w_wdata_rep[8*gi +: 8] =
                !req_is_store ? 8'h00 :
                w_is_word     ? req_wdata[8*gi +: 8] :
                w_is_half     ? (LANE[0] ? req_wdata[15:8] : req_wdata[7:0]) :
                                req_wdata[7:0];
        end
    endgenerate

    // right-align the returned word by the latched byte offset
    assign w_load_aligned = mem_rdata >> {r_offset, 3'b000};

    // sequencer FSM with registered outputs; completion and exception flags are one-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_is_store      <= 1'b0;
            r_rd            <= 5'd0;
            r_offset        <= 2'b00;
            r_ldx_sel       <= 3'b000;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= 32'd0;
            r_mem_we        <= 4'b0000;
            r_mem_wdata     <= 32'd0;
            r_resp_valid    <= 1'b0;
            r_resp_rf_we    <= 1'b0;
            r_resp_rd       <= 5'd0;
            r_resp_data     <= 32'd0;
            r_resp_ldx_sel  <= 3'b000;
            r_exc_valid     <= 1'b0;
            r_exc_addr      <= 32'd0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rf_we <= 1'b0;
            r_exc_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_fault) begin
                            r_exc_valid <= 1'b1;
                            r_exc_addr  <= req_addr;
                        end else begin
                            r_state         <= S_REQ;
                            r_is_store      <= req_is_store;
                            r_rd            <= req_rd;
                            r_offset        <= req_addr[1:0];
                            r_ldx_sel       <= w_ldx_sel;
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= {req_addr[31:2], 2'b00};
                            r_mem_we        <= w_be;
                            r_mem_wdata     <= w_wdata_rep;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        if (r_is_store) begin
                            r_state        <= S_IDLE;
                            r_resp_valid   <= 1'b1;
                            r_resp_rd      <= 5'd0;
                            r_resp_data    <= 32'd0;
                            r_resp_ldx_sel <= 3'b000;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_state        <= S_IDLE;
                        r_resp_valid   <= 1'b1;
                        r_resp_rf_we   <= 1'b1;
                        r_resp_rd      <= r_rd;
                        r_resp_data    <= w_load_aligned;
                        r_resp_ldx_sel <= r_ldx_sel;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_we        = r_mem_we;
    assign mem_wdata     = r_mem_wdata;
    assign resp_valid    = r_resp_valid;
    assign resp_rf_we    = r_resp_rf_we;
    assign resp_rd       = r_resp_rd;
    assign resp_data     = r_resp_data;
    assign resp_ldx_sel  = r_resp_ldx_sel;
    assign exc_valid     = r_exc_valid;
    assign exc_addr      = r_exc_addr;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed expectations for load_store_unit.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_rf_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic [2:0]  resp_ldx_sel;
    logic        exc_valid;
    logic [31:0] exc_addr;

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .resp_valid     (resp_valid),
        .resp_rf_we     (resp_rf_we),
        .resp_rd        (resp_rd),
        .resp_data      (resp_data),
        .resp_ldx_sel   (resp_ldx_sel),
        .exc_valid      (exc_valid),
        .exc_addr       (exc_addr)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
        check("req_ready_before_accept", req_ready, 1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                            input logic [31:0] rdata, input int req_delay, input int resp_delay,
                            input logic [31:0] exp_data, input logic [2:0] exp_sel);
        logic [31:0] exp_word;
        exp_word = {addr[31:2], 2'b00};
        present(1'b0, f3, addr, 32'h0, rd);
        for (int i = 0; i < req_delay; i++) begin
            check("ld_stall_req_valid", mem_req_valid, 1);
            check("ld_stall_addr", mem_addr, exp_word);
            check("ld_stall_we", mem_we, 0);
            check("ld_stall_req_ready", req_ready, 0);
            tick();
        end
        mem_req_ready = 1'b1;
        check("ld_req_valid", mem_req_valid, 1);
        check("ld_addr", mem_addr, exp_word);
        check("ld_we", mem_we, 0);
        tick();
        mem_req_ready = 1'b0;
        check("ld_req_dropped", mem_req_valid, 0);
        for (int i = 0; i < resp_delay; i++) begin
            check("ld_wait_resp_valid", resp_valid, 0);
            check("ld_wait_req_ready", req_ready, 0);
            tick();
        end
        check("ld_pre_resp_valid", resp_valid, 0);
        mem_resp_valid = 1'b1;
        mem_rdata      = rdata;
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        check("ld_resp_valid", resp_valid, 1);
        check("ld_rf_we", resp_rf_we, 1);
        check("ld_rd", resp_rd, rd);
        check("ld_data", resp_data, exp_data);
        check("ld_sel", resp_ldx_sel, exp_sel);
        check("ld_resp_req_ready", req_ready, 1);
        tick();
        check("ld_resp_once", resp_valid, 0);
        $display("load  f3=%b addr=%h rdata=%h -> data=%h sel=%b", f3, addr, rdata, resp_data, resp_ldx_sel);
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                             input int req_delay, input logic [31:0] exp_addr,
                             input logic [3:0] exp_we, input logic [31:0] exp_wdata);
        present(1'b1, f3, addr, wdata, 5'd9);
        for (int i = 0; i < req_delay; i++) begin
            check("st_stall_addr", mem_addr, exp_addr);
            check("st_stall_we", mem_we, exp_we);
            check("st_stall_wdata", mem_wdata, exp_wdata);
            check("st_stall_req_ready", req_ready, 0);
            tick();
        end
        mem_req_ready = 1'b1;
        check("st_req_valid", mem_req_valid, 1);
        check("st_addr", mem_addr, exp_addr);
        check("st_we", mem_we, exp_we);
        check("st_wdata", mem_wdata, exp_wdata);
        tick();
        mem_req_ready = 1'b0;
        check("st_resp_valid", resp_valid, 1);
        check("st_rf_we", resp_rf_we, 0);
        check("st_rd", resp_rd, 0);
        check("st_data", resp_data, 0);
        check("st_req_ready", req_ready, 1);
        check("st_req_dropped", mem_req_valid, 0);
        tick();
        check("st_resp_once", resp_valid, 0);
        $display("store f3=%b addr=%h wdata=%h -> we=%b mem_wdata=%h", f3, addr, wdata, exp_we, exp_wdata);
    endtask

    task automatic run_exc(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        present(st, f3, addr, 32'h5555_AAAA, 5'd3);
        check("exc_valid", exc_valid, 1);
        check("exc_addr", exc_addr, addr);
        check("exc_no_mem_req", mem_req_valid, 0);
        check("exc_req_ready", req_ready, 1);
        check("exc_no_resp", resp_valid, 0);
        tick();
        check("exc_pulse", exc_valid, 0);
        check("exc_no_mem_req_late", mem_req_valid, 0);
        $display("exc   st=%b f3=%b addr=%h -> exc_addr=%h", st, f3, addr, exc_addr);
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_req_ready"}, req_ready, 1);
        check({phase, "_mem_req_valid"}, mem_req_valid, 0);
        check({phase, "_mem_addr"}, mem_addr, 0);
        check({phase, "_mem_we"}, mem_we, 0);
        check({phase, "_mem_wdata"}, mem_wdata, 0);
        check({phase, "_resp_valid"}, resp_valid, 0);
        check({phase, "_resp_rf_we"}, resp_rf_we, 0);
        check({phase, "_resp_rd"}, resp_rd, 0);
        check({phase, "_resp_data"}, resp_data, 0);
        check({phase, "_resp_ldx_sel"}, resp_ldx_sel, 0);
        check({phase, "_exc_valid"}, exc_valid, 0);
        check({phase, "_exc_addr"}, exc_addr, 0);
    endtask

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_is_store   = 1'b0;
        req_funct3     = 3'b000;
        req_addr       = 32'h0;
        req_wdata      = 32'h0;
        req_rd         = 5'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();
        $display("reset done");

        // loads: word, bytes, halves at different offsets
        run_load(3'b010, 32'h0000_1000, 5'd1, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 3'b000);
        run_load(3'b000, 32'h0000_1003, 5'd2, 32'h8011_2233, 0, 0, 32'h0000_0080, 3'b100);
        run_load(3'b101, 32'h0000_1002, 5'd4, 32'h8011_2233, 0, 0, 32'h0000_8011, 3'b001);
        run_load(3'b001, 32'h0000_1002, 5'd5, 32'h8011_2233, 0, 0, 32'h0000_8011, 3'b010);
        run_load(3'b100, 32'h0000_1001, 5'd6, 32'h8011_2233, 0, 0, 32'h0080_1122, 3'b011);

        // stores: lane enables and replication
        run_store(3'b000, 32'h0000_2001, 32'h0000_00AB, 0, 32'h0000_2000, 4'b0010, 32'hABAB_ABAB);
        run_store(3'b001, 32'h0000_2002, 32'h0000_1234, 0, 32'h0000_2000, 4'b1100, 32'h1234_1234);
        run_store(3'b010, 32'h0000_2004, 32'hCAFE_F00D, 2, 32'h0000_2004, 4'b1111, 32'hCAFE_F00D);
        run_store(3'b000, 32'h0000_2003, 32'h7654_32C9, 1, 32'h0000_2000, 4'b1000, 32'hC9C9_C9C9);

        // misaligned and illegal operations
        run_exc(1'b0, 3'b010, 32'h0000_1002);
        run_exc(1'b1, 3'b001, 32'h0000_3001);
        run_exc(1'b0, 3'b011, 32'h0000_1000);
        run_exc(1'b1, 3'b100, 32'h0000_4000);

        // stalled request then delayed response
        run_load(3'b010, 32'h0000_1008, 5'd7, 32'h0BAD_F00D, 3, 4, 32'h0BAD_F00D, 3'b000);

        // reset while waiting for a load response; the late response must be dropped
        present(1'b0, 3'b010, 32'h0000_100C, 32'h0, 5'd8);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("rstw_in_wait", req_ready, 0);
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1357_9BDF;
        check_reset_outputs("rstw");
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        check("rstw_late_resp_dropped", resp_valid, 0);
        check("rstw_idle", req_ready, 1);
        tick();
        check("rstw_no_resp_later", resp_valid, 0);
        $display("reset in WAIT: late response discarded");
        run_load(3'b010, 32'h0000_1010, 5'd10, 32'h2468_ACE0, 0, 0, 32'h2468_ACE0, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
